// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults, width helpers and step type for the lamp sequence detector
package seq_det_pkg;

    localparam int DEF_N_LAMPS = 3;
    localparam int DEF_SEQ_LEN = 3;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_STICKY  = 0;

    // Largest supported sequence; the internal step register is sized for it.
    localparam int MAX_SEQ_LEN = 8;
    localparam int STEP_REG_W  = $clog2(MAX_SEQ_LEN + 1);
    localparam int STEP_SPAN   = 2 ** STEP_REG_W;

    // Idle counter width covers the full TIMEOUT range 1..255.
    localparam int IDLE_W = 8;

    typedef logic [STEP_REG_W-1:0] step_t;

    // Width of the step output: positions 0..seq_len.
    function automatic int step_width(input int seq_len);
        return $clog2(seq_len + 1);
    endfunction

    // Width of the slot index: slots 0..seq_len-1.
    function automatic int slot_width(input int seq_len);
        return $clog2(seq_len);
    endfunction

    localparam int DEF_STEP_W = step_width(DEF_SEQ_LEN);
    localparam int DEF_SLOT_W = slot_width(DEF_SEQ_LEN);

endpackage

// File: rtl/seq_timeout_ctr.sv
// rtl/seq_timeout_ctr.sv - idle counter that flags when a step has been held too long
module seq_timeout_ctr
    import seq_det_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam logic [IDLE_W-1:0] LIMIT = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] cnt;

    // Count hold cycles, restarting whenever the step moves; stop at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (enable && (cnt < LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable one-hot lamp sequence detector with timeout and hit counter
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int N_LAMPS = DEF_N_LAMPS,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int STICKY  = DEF_STICKY
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_LAMPS-1:0]                 lamps,
    input  logic                               cfg_we,
    input  logic [slot_width(SEQ_LEN)-1:0]     cfg_slot,
    input  logic [$clog2(N_LAMPS)-1:0]         cfg_lamp,
    input  logic                               clear,
    output logic                               alarme,
    output logic [step_width(SEQ_LEN)-1:0]     step,
    output logic [7:0]                         hits
);

    localparam int    STEP_W = step_width(SEQ_LEN);
    localparam int    LAMP_W = $clog2(N_LAMPS);
    localparam step_t LAST   = step_t'(SEQ_LEN);

    logic [LAMP_W-1:0]    seq [SEQ_LEN];
    logic [SEQ_LEN-1:0]   match;
    logic [STEP_SPAN-1:0] match_ext;
    step_t                step_q;
    step_t                step_d;
    step_t                step_m1;
    logic                 cfg_ok;
    logic                 in_mid;
    logic                 expired;
    logic                 advance;
    logic                 hold_prev;
    logic                 entering_last;
    logic [7:0]           hits_q;

    // A slot matches only when exactly its stored lamp is on and nothing else.
    always_comb begin
        match = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            match[i] = (lamps == (N_LAMPS'(1) << seq[i]));
        end
    end

    assign match_ext = {{(STEP_SPAN - SEQ_LEN){1'b0}}, match};
    assign cfg_ok    = cfg_we && (int'(cfg_slot) < SEQ_LEN) && (int'(cfg_lamp) < N_LAMPS);
    assign in_mid    = (step_q != '0) && (step_q < LAST);

    // Next step: clear, then slot write, then timeout, then the lamp rules.
    always_comb begin
        step_d    = step_q;
        step_m1   = step_q - step_t'(1);
        advance   = (step_q < LAST) && match_ext[step_q];
        hold_prev = (step_q != '0) && match_ext[step_m1];
        if (clear || cfg_ok || (in_mid && expired)) begin
            step_d = '0;
        end else if (advance) begin
            step_d = step_q + step_t'(1);
        end else if (hold_prev) begin
            step_d = step_q;
        end else if (match[0]) begin
            step_d = step_t'(1);
        end else begin
            step_d = '0;
        end
    end

    assign entering_last = (step_d == LAST) && (step_q != LAST);

    // Step position and saturating detection count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= '0;
            hits_q <= '0;
        end else begin
            step_q <= step_d;
            if (entering_last && (hits_q != 8'hFF)) begin
                hits_q <= hits_q + 8'd1;
            end
        end
    end

    // Sequence table; reset restores the identity-like default ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                seq[i] <= LAMP_W'(i % N_LAMPS);
            end
        end else if (cfg_ok && !clear) begin
            seq[cfg_slot] <= cfg_lamp;
        end
    end

    seq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .reload  (step_d != step_q),
        .enable  (in_mid),
        .expired (expired)
    );

    generate
        if (STICKY != 0) begin : g_sticky
            logic alarm_q;

            // Latched alarm: set on arrival at the last step, dropped only by clear.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    alarm_q <= 1'b0;
                end else if (clear) begin
                    alarm_q <= 1'b0;
                end else if (entering_last) begin
                    alarm_q <= 1'b1;
                end
            end

            assign alarme = alarm_q;
        end else begin : g_level
            assign alarme = (step_q == LAST);
        end
    endgenerate

    assign step = step_q[STEP_W-1:0];
    assign hits = hits_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param (level and sticky variants)
module tb_seq_detector_param;

    localparam int L  = 3;
    localparam int NL = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] lamps;
    logic       cfg_we;
    logic [1:0] cfg_slot;
    logic [1:0] cfg_lamp;
    logic       clear;
    logic       alarme0, alarme1;
    logic [1:0] step0, step1;
    logic [7:0] hits0, hits1;

    typedef struct {
        int step0; int al0; int hits0;
        int step1; int al1; int hits1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int m_seq  [2][L];
    int m_step [2];
    int m_idle [2];
    int m_hits [2];
    int m_alarm[2];
    int m_tmo  [2] = '{16, 4};
    int m_stk  [2] = '{0, 1};

    always #5 clk = ~clk;

    seq_detector_param #(.N_LAMPS(3), .SEQ_LEN(3), .TIMEOUT(16), .STICKY(0)) dut0 (
        .clk(clk), .reset(reset), .lamps(lamps), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
        .cfg_lamp(cfg_lamp), .clear(clear), .alarme(alarme0), .step(step0), .hits(hits0)
    );

    seq_detector_param #(.N_LAMPS(3), .SEQ_LEN(3), .TIMEOUT(4), .STICKY(1)) dut1 (
        .clk(clk), .reset(reset), .lamps(lamps), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
        .cfg_lamp(cfg_lamp), .clear(clear), .alarme(alarme1), .step(step1), .hits(hits1)
    );

    function automatic int lit_lamp(input logic [2:0] v);
        int idx = -1;
        if ($countones(v) == 1) begin
            for (int i = 0; i < NL; i++) if (v[i]) idx = i;
        end
        return idx;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < L; i++) m_seq[d][i] = i % NL;
            m_step[d] = 0; m_idle[d] = 0; m_hits[d] = 0; m_alarm[d] = 0;
        end
    endtask

    task automatic model_edge(input logic [2:0] lv, input bit clr, input bit we, input int slot, input int lamp);
        int k, ns;
        k = lit_lamp(lv);
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                ns = 0;
                m_alarm[d] = 0;
            end else if (we && slot < L && lamp < NL) begin
                m_seq[d][slot] = lamp;
                ns = 0;
            end else if (m_step[d] > 0 && m_step[d] < L && m_idle[d] >= m_tmo[d]) begin
                ns = 0;
            end else if (m_step[d] < L && k == m_seq[d][m_step[d]]) begin
                ns = m_step[d] + 1;
            end else if (m_step[d] > 0 && k == m_seq[d][m_step[d]-1]) begin
                ns = m_step[d];
            end else begin
                ns = (k == m_seq[d][0]) ? 1 : 0;
            end
            if (ns != m_step[d]) m_idle[d] = 0;
            else if (m_step[d] > 0 && m_step[d] < L) m_idle[d] = m_idle[d] + 1;
            if (ns == L && m_step[d] != L) begin
                if (m_hits[d] < 255) m_hits[d] = m_hits[d] + 1;
                if (m_stk[d] != 0) m_alarm[d] = 1;
            end
            if (m_stk[d] == 0) m_alarm[d] = (ns == L) ? 1 : 0;
            m_step[d] = ns;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.step0 = m_step[0]; e.al0 = m_alarm[0]; e.hits0 = m_hits[0];
        e.step1 = m_step[1]; e.al1 = m_alarm[1]; e.hits1 = m_hits[1];
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic [2:0] lv, input bit clr, input bit we, input int slot, input int lamp);
        @(negedge clk);
        #1;
        reset    = 1'b0;
        lamps    = lv;
        clear    = clr;
        cfg_we   = we;
        cfg_slot = 2'(slot);
        cfg_lamp = 2'(lamp);
        model_edge(lv, clr, we, slot, lamp);
        push_exp();
    endtask

    task automatic l(input logic [2:0] lv);
        apply(lv, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset  = 1'b1;
        lamps  = '0; clear = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_lamp = '0;
        model_reset();
        push_exp();
    endtask

    task automatic check(input string name, input logic [31:0] act, input int expv);
        n_checks++;
        if (act === 32'(expv)) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    // Monitor: one output observation per cycle, compared against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("step_level",   32'(step0),   e.step0);
            check("alarme_level", 32'(alarme0), e.al0);
            check("hits_level",   32'(hits0),   e.hits0);
            check("step_sticky",  32'(step1),   e.step1);
            check("alarme_sticky",32'(alarme1), e.al1);
            check("hits_sticky",  32'(hits1),   e.hits1);
        end
    end

    initial begin
        logic [2:0] prev;
        int r, r2;
        reset = 1'b1; lamps = '0; clear = 1'b0; cfg_we = 1'b0; cfg_slot = '0; cfg_lamp = '0;
        model_reset();
        do_reset();
        do_reset();

        // Basic detection, then lamp holds inside the sequence
        l(3'b001); l(3'b010); l(3'b100); l(3'b000);
        l(3'b001); l(3'b001); l(3'b010); l(3'b010); l(3'b100); l(3'b100); l(3'b000);

        // Multi-hot, zero-hot and restart-on-first-lamp patterns
        l(3'b001); l(3'b011); l(3'b001); l(3'b000); l(3'b010); l(3'b001); l(3'b000);

        // Short timeout: four holds expire, three holds then advance survive
        repeat (6) l(3'b001);
        l(3'b000);
        repeat (4) l(3'b001);
        l(3'b010); l(3'b100); l(3'b000);

        // Long timeout on the level variant
        repeat (19) l(3'b001);
        l(3'b000);

        // Sticky alarm survives lamps off, clear drops it
        l(3'b001); l(3'b010); l(3'b100); l(3'b000); l(3'b000);
        apply(3'b000, 1'b1, 1'b0, 0, 0);
        l(3'b000);

        // Out-of-range slot and lamp writes are ignored
        l(3'b001);
        apply(3'b010, 1'b0, 1'b1, 3, 0);
        apply(3'b100, 1'b0, 1'b1, 0, 3);
        l(3'b000);

        // Reprogram to {2,0,1} while at step 2, detect, then reset mid-sequence
        l(3'b001); l(3'b010);
        apply(3'b000, 1'b0, 1'b1, 0, 2);
        apply(3'b000, 1'b0, 1'b1, 1, 0);
        apply(3'b000, 1'b0, 1'b1, 2, 1);
        l(3'b100); l(3'b001); l(3'b010); l(3'b000);
        l(3'b100);
        do_reset();
        l(3'b001); l(3'b010); l(3'b100); l(3'b000);

        // Hit counter saturation
        repeat (258) begin
            l(3'b001); l(3'b010); l(3'b100); l(3'b000);
        end

        // Randomised traffic
        prev = 3'b000;
        repeat (2000) begin
            logic [2:0] lv;
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            if (r2 < 35)      lv = prev;
            else if (r2 < 80) lv = 3'(1 << $urandom_range(0, 2));
            else              lv = 3'($urandom_range(0, 7));
            if (r < 1)        do_reset();
            else if (r < 3)   apply(lv, 1'b1, 1'b0, 0, 0);
            else if (r < 6)   apply(lv, 1'b0, 1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
            else              l(lv);
            prev = lv;
        end

        l(3'b000);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter N_LAMPS, default 3: number of lamp inputs (2..16).
REQ-002 SHALL have parameter SEQ_LEN, default 3: number of steps in the sequence (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum cycles allowed between accepted steps (1..255).
REQ-004 SHALL have parameter STICKY, default 0: 0 = alarm is a level while in the final step; 1 = alarm latches until clear.
REQ-005 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port lamps, input, N_LAMPS: lamp-on vector, sampled every cycle.
REQ-008 SHALL have port cfg_we, input, 1: write strobe for one sequence slot.
REQ-009 SHALL have port cfg_slot, input, clog2(SEQ_LEN): slot index to write.
REQ-010 SHALL have port cfg_lamp, input, clog2(N_LAMPS): lamp index to store in that slot.
REQ-011 SHALL have port clear, input, 1: synchronous clear of the alarm and the step position.
REQ-012 SHALL have port alarme, output, 1: detection alarm.
REQ-013 SHALL have port step, output, clog2(SEQ_LEN+1): current step position (0..SEQ_LEN).
REQ-014 SHALL have port hits, output, 8: count of completed detections, saturating at 255.

Function
REQ-015 SHALL store the sequence seq[0..SEQ_LEN-1] as lamp indices; the reset value is seq[i] = i mod N_LAMPS.
REQ-016 SHALL define a pattern as valid for lamp k only when lamps is exactly one-hot with bit k set; zero-hot and multi-hot patterns are never valid.
REQ-017 SHALL advance step from p to p+1 (p < SEQ_LEN) when lamps is valid for seq[p].
REQ-018 SHALL hold step p > 0 when lamps is valid for seq[p-1], i.e. the previous lamp is still on.
REQ-019 SHALL, on any other pattern, set step to 1 if lamps is valid for seq[0], else to 0.
REQ-020 SHALL, at step == SEQ_LEN, apply REQ-018/REQ-019, with step SEQ_LEN holding while seq[SEQ_LEN-1] stays on.
REQ-021 SHALL increment hits once, on the transition into step == SEQ_LEN, saturating at 255.
REQ-022 SHALL drive alarme = (step == SEQ_LEN) when STICKY = 0; when STICKY = 1, alarme sets on entry to SEQ_LEN and remains 1 until clear or reset.
REQ-023 SHALL keep an idle counter for 0 < step < SEQ_LEN: it reloads on each advance and, after TIMEOUT consecutive hold cycles, forces step to 0 on the next edge.
REQ-024 SHALL have no timeout at step 0 or at step SEQ_LEN.
REQ-025 SHALL, on cfg_we, write seq[cfg_slot] = cfg_lamp and force step to 0 in the same edge; hits and alarme are unaffected.
REQ-026 SHALL ignore cfg_we when cfg_slot >= SEQ_LEN or cfg_lamp >= N_LAMPS.
REQ-027 SHALL apply priority per edge in the order clear, then cfg_we, then timeout, then the step rules; clear forces step to 0 and alarme to 0 and leaves hits unchanged.
REQ-028 SHALL produce all outputs from registers or step decode, so an input pattern is reflected on outputs one cycle later.

Reset
REQ-029 SHALL, on reset assertion, asynchronously set step = 0, alarme = 0, hits = 0 and idle counter = 0.
REQ-030 SHALL also restore seq to the REQ-015 defaults on reset, including when reset is asserted mid-sequence.
REQ-031 SHALL leave state unchanged in the first edge after reset deasserts unless lamps is valid for seq[0].

Structure
REQ-032 SHALL place the default parameter values, the clog2-based step and slot width constants, and the step_t typedef in a shared package seq_det_pkg.
REQ-033 SHALL implement the idle counter as the sub-module seq_timeout_ctr, with ports clk, reset, reload, enable and expired.

Verification
REQ-034 SHALL verify, with defaults: lamps 001, 010, 100 on consecutive cycles -> step 1, 2, 3; alarme = 1 one cycle after 100; hits = 1.
REQ-035 SHALL verify: lamps 001, 001, 010, 010, 100 -> detection succeeds; holding a step's lamp keeps that step.
REQ-036 SHALL verify: lamps 001, 011 -> step 0; lamps 001, 000 -> step 0; lamps 010, 001 -> step 1.
REQ-037 SHALL verify, with TIMEOUT = 4: lamps 001 then 001 held for 4 cycles -> step 0 on the following edge; 001 held for 3 cycles then 010 -> step 2.
REQ-038 SHALL verify, with STICKY = 1: complete the sequence, then lamps 000 -> alarme stays 1 and step = 0; clear -> alarme = 0; 256 detections -> hits = 255.
REQ-039 SHALL verify: write cfg seq = {2, 0, 1} while at step 2 -> step = 0; then lamps 100, 001, 010 -> alarme; reset mid-sequence -> seq = {0, 1, 2} and all outputs = 0.
